// File: rtl/cas_sort_pipe.sv
// Pipelined odd-even transposition sorter with a valid/ready handshake and bubble-collapsing stages.
// Optional index tags on out_idx are enabled by defining CAS_SORT_INDEX_EN.
module cas_sort_pipe #(
  parameter int unsigned SNG_WIDTH  = 4,
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned IDX_W      = $clog2(NUM_INPUTS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_INPUTS*SNG_WIDTH-1:0]  in_data,
  input  logic                             in_descend,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_INPUTS*SNG_WIDTH-1:0]  out_data
`ifdef CAS_SORT_INDEX_EN
  ,
  output logic [NUM_INPUTS*IDX_W-1:0]      out_idx
`endif
);

  localparam int unsigned W  = SNG_WIDTH;
  localparam int unsigned N  = NUM_INPUTS;
  localparam int unsigned VW = N * W;

  if (N < 2 || IDX_W < $clog2(N)) begin : g_cfg_check
    $error("cas_sort_pipe: NUM_INPUTS must be >= 2 and IDX_W >= clog2(NUM_INPUTS)");
  end

  // One subtract per pair: the borrow gives lane[i] < lane[i+1], a non-zero
  // result without borrow gives lane[i] > lane[i+1]; equal never swaps.
  function automatic logic [N-1:0] swap_mask(input logic [VW-1:0] v,
                                              input logic        desc,
                                              input int unsigned first);
    logic [W:0] diff;
    swap_mask = '0;
    for (int unsigned i = first; i + 1 < N; i += 2) begin
      diff = {1'b0, v[i*W +: W]} - {1'b0, v[(i+1)*W +: W]};
      if (desc) swap_mask[i] = diff[W];
      else      swap_mask[i] = ~diff[W] & (|diff[W-1:0]);
    end
  endfunction

  function automatic logic [VW-1:0] swap_data(input logic [VW-1:0] v,
                                               input logic [N-1:0]  mask);
    swap_data = v;
    for (int unsigned i = 0; i + 1 < N; i++) begin
      if (mask[i]) begin
        swap_data[i*W +: W]     = v[(i+1)*W +: W];
        swap_data[(i+1)*W +: W] = v[i*W +: W];
      end
    end
  endfunction

  logic [N-1:0]  st_valid;
  logic [N-1:0]  st_desc;
  logic [VW-1:0] st_data [N];

  logic [N-1:0]  up_valid;
  logic [N-1:0]  up_desc;
  logic [VW-1:0] up_data  [N];
  logic [VW-1:0] cas_data [N];
  logic [N-1:0]  mask     [N];
  logic [N:0]    rdy;
  logic [N-1:0]  load;

  assign up_valid = {st_valid[N-2:0], in_valid};
  assign up_desc  = {st_desc[N-2:0], in_descend};

  always_comb begin
    up_data[0] = in_data;
    for (int unsigned s = 1; s < N; s++) begin
      up_data[s] = st_data[s-1];
    end
    for (int unsigned s = 0; s < N; s++) begin
      mask[s]     = swap_mask(up_data[s], up_desc[s], s % 2);
      cas_data[s] = swap_data(up_data[s], mask[s]);
    end
  end

  // rdy[j]: stage j can take a vector, i.e. out_ready or any empty stage at or after j.
  always_comb begin
    logic acc;
    acc    = out_ready;
    rdy    = '0;
    rdy[N] = out_ready;
    for (int unsigned j = N; j > 0; j--) begin
      acc      = acc | ~st_valid[j-1];
      rdy[j-1] = acc;
    end
  end

  assign load = up_valid & rdy[N-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      st_valid <= '0;
      st_desc  <= '0;
      for (int unsigned s = 0; s < N; s++) begin
        st_data[s] <= '0;
      end
    end else begin
      st_valid <= load | (st_valid & ~rdy[N:1]);
      for (int unsigned s = 0; s < N; s++) begin
        if (load[s]) begin
          st_data[s] <= cas_data[s];
          st_desc[s] <= up_desc[s];
        end
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = st_valid[N-1];
  assign out_data  = st_data[N-1];

`ifdef CAS_SORT_INDEX_EN
  localparam int unsigned TW = N * IDX_W;

  function automatic logic [TW-1:0] swap_idx(input logic [TW-1:0] v,
                                             input logic [N-1:0]  m);
    swap_idx = v;
    for (int unsigned i = 0; i + 1 < N; i++) begin
      if (m[i]) begin
        swap_idx[i*IDX_W +: IDX_W]     = v[(i+1)*IDX_W +: IDX_W];
        swap_idx[(i+1)*IDX_W +: IDX_W] = v[i*IDX_W +: IDX_W];
      end
    end
  endfunction

  logic [TW-1:0] st_idx  [N];
  logic [TW-1:0] up_idx  [N];
  logic [TW-1:0] cas_idx [N];

  always_comb begin
    up_idx[0] = '0;
    for (int unsigned k = 0; k < N; k++) begin
      up_idx[0][k*IDX_W +: IDX_W] = IDX_W'(k);
    end
    for (int unsigned s = 1; s < N; s++) begin
      up_idx[s] = st_idx[s-1];
    end
    for (int unsigned s = 0; s < N; s++) begin
      cas_idx[s] = swap_idx(up_idx[s], mask[s]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < N; s++) begin
        st_idx[s] <= '0;
      end
    end else begin
      for (int unsigned s = 0; s < N; s++) begin
        if (load[s]) st_idx[s] <= cas_idx[s];
      end
    end
  end

  assign out_idx = st_idx[N-1];
`else
  // Without tags the data path above is complete; no tag state exists.
`endif

endmodule

// File: tb/tb_cas_sort_pipe.sv
// Directed self-checking bench for cas_sort_pipe (4 lanes x 4 bits) with an expected-output queue.
// Index checks are compiled in when CAS_SORT_INDEX_EN is defined.
module tb_cas_sort_pipe;
  localparam int unsigned W  = 4;
  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N*W-1:0] in_data;
  logic          in_descend;
  logic          out_valid;
  logic          out_ready;
  logic [N*W-1:0] out_data;
`ifdef CAS_SORT_INDEX_EN
  logic [N*IW-1:0] out_idx;
`endif

  always #5 clk = ~clk;

  cas_sort_pipe #(.SNG_WIDTH(W), .NUM_INPUTS(N), .IDX_W(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_descend (in_descend),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
`ifdef CAS_SORT_INDEX_EN
    ,
    .out_idx    (out_idx)
`endif
  );

  typedef struct packed {
    logic [15:0] d;
    logic [7:0]  ix;
  } exp_t;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  exp_t        exp_q[$];
  exp_t        cur;

  logic [15:0] vin   [11];
  logic        vdesc [11];
  logic [15:0] vexp  [11];
  logic [7:0]  vix   [11];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pk4(input int a0, input int a1, input int a2, input int a3);
    return {4'(a3), 4'(a2), 4'(a1), 4'(a0)};
  endfunction

  function automatic logic [7:0] pk2(input int a0, input int a1, input int a2, input int a3);
    return {2'(a3), 2'(a2), 2'(a1), 2'(a0)};
  endfunction

  task automatic set_vec(input int k, input logic [15:0] d, input logic desc,
                         input logic [15:0] e, input logic [7:0] ix);
    vin[k] = d; vdesc[k] = desc; vexp[k] = e; vix[k] = ix;
  endtask

  // Settle, score the handshakes about to happen at the next edge, then cross it.
  task automatic tick(output logic acc);
    exp_t e;
    #1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("out_data", 32'(out_data), 32'(e.d));
`ifdef CAS_SORT_INDEX_EN
        check_eq("out_idx", 32'(out_idx), 32'(e.ix));
`endif
      end
    end
    acc = in_valid && in_ready;
    if (acc) exp_q.push_back(cur);
    @(posedge clk);
    #1;
  endtask

  task automatic send_range(input int lo, input int hi, input int cycles,
                            output int next_k, output int n_acc);
    int   k;
    logic a;
    k = lo;
    n_acc = 0;
    for (int c = 0; c < cycles; c++) begin
      if (k <= hi) begin
        in_valid   = 1'b1;
        in_data    = vin[k];
        in_descend = vdesc[k];
        cur        = '{d: vexp[k], ix: vix[k]};
      end else begin
        in_valid = 1'b0;
      end
      tick(a);
      if (a) begin
        k++;
        n_acc++;
      end
    end
    in_valid = 1'b0;
    next_k = k;
  endtask

  task automatic drain_all();
    logic a;
    in_valid = 1'b0;
    for (int c = 0; c < 30 && exp_q.size() != 0; c++) tick(a);
    check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
    tick(a);
    tick(a);
  endtask

  initial begin
    logic a;
    int   k;
    int   n;

    set_vec(0,  pk4(3,0,2,1),     1'b1, pk4(3,2,1,0),     pk2(0,2,3,1));
    set_vec(1,  pk4(3,0,2,1),     1'b0, pk4(0,1,2,3),     pk2(1,3,2,0));
    set_vec(2,  pk4(15,0,15,0),   1'b1, pk4(15,15,0,0),   pk2(0,2,1,3));
    set_vec(3,  pk4(15,0,15,0),   1'b0, pk4(0,0,15,15),   pk2(1,3,0,2));
    set_vec(4,  pk4(15,15,15,15), 1'b0, pk4(15,15,15,15), pk2(0,1,2,3));
    set_vec(5,  pk4(4,3,2,1),     1'b0, pk4(1,2,3,4),     pk2(3,2,1,0));
    set_vec(6,  pk4(9,9,1,0),     1'b1, pk4(9,9,1,0),     pk2(0,1,2,3));
    set_vec(7,  pk4(0,5,10,15),   1'b1, pk4(15,10,5,0),   pk2(3,2,1,0));
    set_vec(8,  pk4(7,7,7,7),     1'b0, pk4(7,7,7,7),     pk2(0,1,2,3));
    set_vec(9,  pk4(12,3,8,5),    1'b0, pk4(3,5,8,12),    pk2(1,3,2,0));
    set_vec(10, pk4(2,14,6,11),   1'b1, pk4(14,11,6,2),   pk2(1,3,2,0));

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_descend = 1'b0; out_ready = 1'b1;
    cur = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_eq("reset_out_valid", 32'(out_valid), 32'd0);
    check_eq("reset_out_data",  32'(out_data),  32'd0);
    check_eq("reset_in_ready",  32'(in_ready),  32'd1);
`ifdef CAS_SORT_INDEX_EN
    check_eq("reset_out_idx",   32'(out_idx),   32'd0);
`endif

    // Single ascending vector: latency of NUM_INPUTS register stages.
    in_valid = 1'b1; in_data = vin[1]; in_descend = 1'b0; cur = '{d: vexp[1], ix: vix[1]};
    tick(a);
    check_eq("lat_accept", 32'(a), 32'd1);
    in_valid = 1'b0;
    tick(a);
    tick(a);
    check_eq("lat_early", 32'(out_valid), 32'd0);
    tick(a);
    check_eq("lat_valid", 32'(out_valid), 32'd1);
    check_eq("lat_data",  32'(out_data),  32'(pk4(0,1,2,3)));
`ifdef CAS_SORT_INDEX_EN
    check_eq("lat_idx",   32'(out_idx),   32'(pk2(1,3,2,0)));
`endif
    drain_all();

    // Back-to-back stream with mixed modes at full throughput.
    out_ready = 1'b1;
    send_range(0, 4, 5, k, n);
    check_eq("stream_accepts", 32'(n), 32'd5);
    drain_all();

    // Backpressure: only four fit, head holds steady, then all six emerge in order.
    out_ready = 1'b0;
    send_range(5, 10, 8, k, n);
    check_eq("bp_accepted", 32'(n), 32'd4);
    check_eq("bp_in_ready", 32'(in_ready), 32'd0);
    check_eq("bp_out_valid", 32'(out_valid), 32'd1);
    check_eq("bp_head", 32'(out_data), 32'(vexp[5]));
    tick(a);
    tick(a);
    check_eq("bp_stable", 32'(out_data), 32'(vexp[5]));
    out_ready = 1'b1;
    send_range(k, 10, 12, k, n);
    check_eq("bp_all_sent", 32'(k), 32'd11);
    drain_all();

    // Bubble collapse: B closes up behind a stalled A.
    out_ready = 1'b0;
    send_range(5, 5, 1, k, n);
    check_eq("bub_a_accept", 32'(n), 32'd1);
    tick(a);
    tick(a);
    send_range(6, 6, 1, k, n);
    check_eq("bub_b_accept", 32'(n), 32'd1);
    tick(a);
    tick(a);
    check_eq("bub_head_valid", 32'(out_valid), 32'd1);
    check_eq("bub_head_data", 32'(out_data), 32'(vexp[5]));
    check_eq("bub_in_ready", 32'(in_ready), 32'd1);
    send_range(7, 9, 4, k, n);
    check_eq("bub_fill", 32'(n), 32'd2);
    check_eq("bub_full", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    send_range(k, 9, 6, k, n);
    check_eq("bub_all_sent", 32'(k), 32'd10);
    drain_all();

    // Reset with three vectors in flight discards them all.
    out_ready = 1'b1;
    send_range(0, 2, 3, k, n);
    check_eq("rst_inflight", 32'(n), 32'd3);
    rst = 1'b1;
    tick(a);
    rst = 1'b0;
    exp_q.delete();
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data",  32'(out_data),  32'd0);
    check_eq("rst_in_ready",  32'(in_ready),  32'd1);
`ifdef CAS_SORT_INDEX_EN
    check_eq("rst_out_idx",   32'(out_idx),   32'd0);
`endif
    repeat (6) tick(a);
    check_eq("rst_no_stale", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
